// File: rtl/packet_fifo_sf_if.sv
// Bundled write/read/status signals of the store-and-forward packet FIFO.
// slave: the FIFO side (takes write beats and rd_ready, drives the read beat and status).
// master: the producer/consumer side, the mirror image of slave.
interface packet_fifo_sf_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
);
    logic              wr_en;
    logic              wr_first;
    logic              wr_last;
    logic              wr_abort;
    logic [DATA_W-1:0] wr_data;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_first;
    logic              rd_last;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   pkt_count;
    logic [CNT_W-1:0]  drop_count;

    modport master (
        output wr_en, wr_first, wr_last, wr_abort, wr_data, rd_ready,
        input  rd_valid, rd_data, rd_first, rd_last,
        input  empty, full, level, pkt_count, drop_count
    );

    modport slave (
        input  wr_en, wr_first, wr_last, wr_abort, wr_data, rd_ready,
        output rd_valid, rd_data, rd_first, rd_last,
        output empty, full, level, pkt_count, drop_count
    );
endinterface

// File: rtl/packet_fifo_sf.sv
// Store-and-forward packet FIFO: beats are staged and only become readable once the last beat lands.
// Latency: last beat accepted at edge N -> rd_valid after edge N+1 (output register free).
// Backpressure: 1-deep registered output held while rd_valid && !rd_ready; oversize packets are dropped whole.
// Ports: clk, rst (async active-high), bus (packet_fifo_sf_if.slave: write beats, read beat, status).
module packet_fifo_sf #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    packet_fifo_sf_if.slave  bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, IN_PKT, DROP} wr_state_t;

    wr_state_t         state, state_nxt;
    logic [ADDR_W:0]   rd_ptr, commit_ptr, wr_ptr, wr_ptr_nxt;
    logic [ADDR_W:0]   base_ptr, base_level, level, pkt_count;
    logic [DATA_W+1:0] mem [DEPTH];
    logic              frame_err, accept, space_ok;
    logic              mem_we, commit, rd_load, rd_take_last;
    logic [1:0]        drop_add;
    logic [CNT_W:0]    drop_sum;
    logic [CNT_W-1:0]  drop_count;
    logic              rd_valid, rd_first, rd_last;
    logic [DATA_W-1:0] rd_data;

    // A first beat always lands at commit_ptr: in IDLE/DROP wr_ptr already equals it,
    // and in IN_PKT it is the framing-error rewind.
    assign base_ptr   = bus.wr_first ? commit_ptr : wr_ptr;
    assign base_level = base_ptr - rd_ptr;
    assign space_ok   = (base_level != DEPTH_L);
    assign frame_err  = (state == IN_PKT) && bus.wr_first;
    assign accept     = (state == IN_PKT) || bus.wr_first;

    // Write FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Write FSM: next state
    always_comb begin
        state_nxt = state;
        if (bus.wr_abort) begin
            state_nxt = IDLE;
        end else if (bus.wr_en) begin
            if (accept)
                state_nxt = bus.wr_last ? IDLE : (space_ok ? IN_PKT : DROP);
            else if (bus.wr_last)
                state_nxt = IDLE;
        end
    end

    // Write FSM: datapath controls
    always_comb begin
        mem_we     = 1'b0;
        wr_ptr_nxt = wr_ptr;
        commit     = 1'b0;
        drop_add   = 2'd0;
        if (bus.wr_abort) begin
            if (state == IN_PKT) begin
                wr_ptr_nxt = commit_ptr;
                drop_add   = 2'd1;
            end
        end else if (bus.wr_en) begin
            if (!accept) begin
                // stray continuation beat outside a packet counts as a drop; in DROP it is expected
                drop_add = {1'b0, state == IDLE};
            end else if (!space_ok) begin
                wr_ptr_nxt = commit_ptr;
                drop_add   = frame_err ? 2'd2 : 2'd1;
            end else begin
                mem_we     = 1'b1;
                wr_ptr_nxt = base_ptr + 1'b1;
                commit     = bus.wr_last;
                drop_add   = {1'b0, frame_err};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[base_ptr[ADDR_W-1:0]] <= {bus.wr_first, bus.wr_last, bus.wr_data};
    end

    assign rd_load      = (!rd_valid || bus.rd_ready) && (rd_ptr != commit_ptr);
    assign rd_take_last = rd_valid && bus.rd_ready && rd_last;
    assign drop_sum     = {1'b0, drop_count} + (CNT_W+1)'(drop_add);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            rd_valid   <= 1'b0;
            rd_first   <= 1'b0;
            rd_last    <= 1'b0;
            rd_data    <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            if (commit)
                commit_ptr <= wr_ptr_nxt;
            if (rd_load) begin
                {rd_first, rd_last, rd_data} <= mem[rd_ptr[ADDR_W-1:0]];
                rd_valid <= 1'b1;
                rd_ptr   <= rd_ptr + 1'b1;
            end else if (bus.rd_ready) begin
                rd_valid <= 1'b0;
            end
            case ({commit, rd_take_last})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
            drop_count <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end
    end

    assign level          = wr_ptr - rd_ptr;
    assign bus.level      = level;
    assign bus.full       = (level == DEPTH_L);
    assign bus.empty      = (rd_ptr == commit_ptr) && !rd_valid;
    assign bus.pkt_count  = pkt_count;
    assign bus.drop_count = drop_count;
    assign bus.rd_valid   = rd_valid;
    assign bus.rd_first   = rd_first;
    assign bus.rd_last    = rd_last;
    assign bus.rd_data    = rd_data;
endmodule

// File: tb/tb_packet_fifo_sf.sv
module tb_packet_fifo_sf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_fifo_sf_if #(.DATA_W(8), .ADDR_W(7), .CNT_W(16)) if7 ();
    packet_fifo_sf_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) if3 ();

    packet_fifo_sf #(.DATA_W(8), .ADDR_W(7), .CNT_W(16)) u7 (.clk(clk), .rst(rst), .bus(if7));
    packet_fifo_sf #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) u3 (.clk(clk), .rst(rst), .bus(if3));

    int checks = 0;
    int errors = 0;
    logic [9:0] got[$];   // {first, last, data} per accepted output beat
    logic [9:0] exp[$];

    task automatic w7(input logic en, input logic f, input logic l, input logic ab, input logic [7:0] d);
        if7.wr_en = en; if7.wr_first = f; if7.wr_last = l; if7.wr_abort = ab; if7.wr_data = d;
    endtask

    task automatic w3(input logic en, input logic f, input logic l, input logic ab, input logic [7:0] d);
        if3.wr_en = en; if3.wr_first = f; if3.wr_last = l; if3.wr_abort = ab; if3.wr_data = d;
    endtask

    // Records each beat the consumer accepts; called at a negedge, returns at a negedge.
    task automatic collect7(input int n);
        for (int i = 0; i < n; i++) begin
            if (if7.rd_valid && if7.rd_ready) got.push_back({if7.rd_first, if7.rd_last, if7.rd_data});
            @(negedge clk);
        end
    endtask

    task automatic collect3(input int n);
        for (int i = 0; i < n; i++) begin
            if (if3.rd_valid && if3.rd_ready) got.push_back({if3.rd_first, if3.rd_last, if3.rd_data});
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++; if (if7.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0h exp 0", if7.rd_valid); end
        checks++; if (if7.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", if7.rd_data); end
        checks++; if (if7.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0h exp 1", if7.empty); end
        checks++; if (if7.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0h exp 0", if7.full); end
        checks++; if (if7.level !== 8'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", if7.level); end
        checks++; if (if7.pkt_count !== 8'd0) begin errors++; $display("FAIL reset_pkt_count got %0d exp 0", if7.pkt_count); end
        checks++; if (if7.drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count got %0d exp 0", if7.drop_count); end
        checks++; if (if3.empty !== 1'b1 || if3.level !== 4'd0) begin errors++; $display("FAIL reset_small got empty %0h level %0d exp 1 0", if3.empty, if3.level); end
    endtask

    task automatic test_single_packet;
        if7.rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); w7(1'b1, i == 0, i == 4, 1'b0, 8'h10 + 8'(i));
        end
        @(negedge clk); w7(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (if7.rd_valid !== 1'b0) begin errors++; $display("FAIL sp_latency got rd_valid %0h exp 0", if7.rd_valid); end
        checks++; if (if7.pkt_count !== 8'd1) begin errors++; $display("FAIL sp_pkt_count_up got %0d exp 1", if7.pkt_count); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (if7.rd_valid !== 1'b1 || if7.rd_data !== 8'h10 + 8'(i) || if7.rd_first !== (i == 0) || if7.rd_last !== (i == 4)) begin
                errors++;
                $display("FAIL sp_beat%0d got v%0h d%0h f%0h l%0h exp v1 d%0h f%0h l%0h", i, if7.rd_valid, if7.rd_data,
                         if7.rd_first, if7.rd_last, 8'h10 + 8'(i), i == 0, i == 4);
            end
        end
        @(negedge clk);
        checks++; if (if7.rd_valid !== 1'b0 || if7.pkt_count !== 8'd0 || if7.empty !== 1'b1) begin
            errors++; $display("FAIL sp_drained got v%0h pkt%0d empty%0h exp v0 pkt0 empty1", if7.rd_valid, if7.pkt_count, if7.empty);
        end
    endtask

    task automatic test_abort;
        if7.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); w7(1'b1, i == 0, 1'b0, 1'b0, 8'h01 + 8'(i));
        end
        @(negedge clk);
        checks++; if (if7.level !== 8'd3 || if7.rd_valid !== 1'b0) begin
            errors++; $display("FAIL ab_staged got level %0d v%0h exp level 3 v0", if7.level, if7.rd_valid);
        end
        w7(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        @(negedge clk); w7(1'b1, 1'b1, 1'b0, 1'b0, 8'hA0);
        @(negedge clk); w7(1'b1, 1'b0, 1'b1, 1'b0, 8'hA1);
        @(negedge clk); w7(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        got.delete(); collect7(10);
        exp = '{{2'b10, 8'hA0}, {2'b01, 8'hA1}};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL ab_count got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL ab_beat%0d got %0h exp %0h", i, (i < got.size()) ? got[i] : 10'h3FF, exp[i]); end
        end
        checks++; if (if7.drop_count !== 16'd1) begin errors++; $display("FAIL ab_drop got %0d exp 1", if7.drop_count); end
        checks++; if (if7.level !== 8'd0) begin errors++; $display("FAIL ab_level got %0d exp 0", if7.level); end
    endtask

    task automatic test_frame_err;
        if7.rd_ready = 1'b1;
        @(negedge clk); w7(1'b1, 1'b1, 1'b0, 1'b0, 8'h61);
        @(negedge clk); w7(1'b1, 1'b0, 1'b0, 1'b0, 8'h62);
        @(negedge clk); w7(1'b1, 1'b1, 1'b0, 1'b0, 8'h70);  // first inside a packet: restart
        @(negedge clk); w7(1'b1, 1'b0, 1'b1, 1'b0, 8'h71);
        @(negedge clk); w7(1'b1, 1'b0, 1'b0, 1'b0, 8'h7F);  // stray beat in IDLE
        @(negedge clk); w7(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        got.delete(); collect7(10);
        exp = '{{2'b10, 8'h70}, {2'b01, 8'h71}};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL fe_count got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL fe_beat%0d got %0h exp %0h", i, (i < got.size()) ? got[i] : 10'h3FF, exp[i]); end
        end
        checks++; if (if7.drop_count !== 16'd3) begin errors++; $display("FAIL fe_drop got %0d exp 3", if7.drop_count); end
    endtask

    task automatic test_backpressure;
        if7.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); w7(1'b1, i == 0, i == 2, 1'b0, 8'h80 + 8'(i));
        end
        @(negedge clk); w7(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (if7.rd_valid !== 1'b1 || if7.rd_data !== 8'h80 || if7.rd_first !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d got v%0h d%0h f%0h exp v1 d80 f1", i, if7.rd_valid, if7.rd_data, if7.rd_first);
            end
            @(negedge clk);
        end
        if7.rd_ready = 1'b1;
        got.delete(); collect7(8);
        exp = '{{2'b10, 8'h80}, {2'b00, 8'h81}, {2'b01, 8'h82}};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL bp_beat%0d got %0h exp %0h", i, (i < got.size()) ? got[i] : 10'h3FF, exp[i]); end
        end
    endtask

    task automatic test_stream;
        int sent = 0;
        int recv = 0;
        int bad = 0;
        int cyc = 0;
        while (recv < 300 && cyc < 5000) begin
            if7.rd_ready = 1'($urandom_range(0, 1));
            if (if7.rd_valid && if7.rd_ready) begin
                if (if7.rd_data !== 8'(recv) || if7.rd_first !== 1'b1 || if7.rd_last !== 1'b1) begin
                    if (bad == 0) $display("FAIL st_order at beat %0d got %0h exp %0h", recv, if7.rd_data, 8'(recv));
                    bad++;
                end
                recv++;
            end
            if (sent < 300 && !if7.full) begin
                w7(1'b1, 1'b1, 1'b1, 1'b0, 8'(sent));
                sent++;
            end else begin
                w7(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            end
            if (recv < 300) @(negedge clk);
            cyc++;
        end
        w7(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        if7.rd_ready = 1'b1;
        checks++; if (recv != 300) begin errors++; $display("FAIL st_count got %0d exp 300", recv); end
        checks++; if (bad != 0) begin errors++; $display("FAIL st_bad_beats got %0d exp 0", bad); end
        @(negedge clk);
        checks++; if (if7.drop_count !== 16'd3) begin errors++; $display("FAIL st_drop got %0d exp 3", if7.drop_count); end
        checks++; if (if7.pkt_count !== 8'd0 || if7.empty !== 1'b1 || if7.level !== 8'd0) begin
            errors++; $display("FAIL st_end got pkt%0d empty%0h level%0d exp pkt0 empty1 level0", if7.pkt_count, if7.empty, if7.level);
        end
    endtask

    // Depth 8: the first packet's head sits in the output register, so storage overflows on the 4th beat.
    task automatic test_overflow;
        if3.rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); w3(1'b1, i == 0, i == 5, 1'b0, 8'h30 + 8'(i));
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 3) begin
                checks++; if (if3.level !== 4'd8 || if3.full !== 1'b1) begin
                    errors++; $display("FAIL ov_full got level %0d full %0h exp 8 1", if3.level, if3.full);
                end
            end
            if (j == 4) begin
                checks++; if (if3.level !== 4'd5 || if3.full !== 1'b0 || if3.drop_count !== 16'd1) begin
                    errors++; $display("FAIL ov_rewind got level %0d full %0h drop %0d exp 5 0 1", if3.level, if3.full, if3.drop_count);
                end
            end
            w3(1'b1, j == 0, j == 4, 1'b0, 8'h40 + 8'(j));
        end
        @(negedge clk);
        checks++; if (if3.level !== 4'd5 || if3.drop_count !== 16'd1 || if3.pkt_count !== 4'd1) begin
            errors++; $display("FAIL ov_drop_state got level %0d drop %0d pkt %0d exp 5 1 1", if3.level, if3.drop_count, if3.pkt_count);
        end
        w3(1'b1, 1'b1, 1'b1, 1'b0, 8'h5A);
        @(negedge clk); w3(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (if3.pkt_count !== 4'd2 || if3.level !== 4'd6) begin
            errors++; $display("FAIL ov_after_drop got pkt %0d level %0d exp 2 6", if3.pkt_count, if3.level);
        end
        if3.rd_ready = 1'b1;
        got.delete(); collect3(20);
        exp = '{{2'b10, 8'h30}, {2'b00, 8'h31}, {2'b00, 8'h32}, {2'b00, 8'h33}, {2'b00, 8'h34}, {2'b01, 8'h35}, {2'b11, 8'h5A}};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL ov_count got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL ov_beat%0d got %0h exp %0h", i, (i < got.size()) ? got[i] : 10'h3FF, exp[i]); end
        end
        checks++; if (if3.pkt_count !== 4'd0 || if3.level !== 4'd0 || if3.empty !== 1'b1) begin
            errors++; $display("FAIL ov_end got pkt %0d level %0d empty %0h exp 0 0 1", if3.pkt_count, if3.level, if3.empty);
        end
    endtask

    task automatic test_reset_mid;
        if7.rd_ready = 1'b0;
        @(negedge clk); w7(1'b1, 1'b1, 1'b0, 1'b0, 8'h90);
        @(negedge clk); w7(1'b1, 1'b0, 1'b1, 1'b0, 8'h91);
        @(negedge clk); w7(1'b1, 1'b1, 1'b0, 1'b0, 8'h92);
        @(negedge clk); w7(1'b1, 1'b0, 1'b0, 1'b0, 8'h93);
        @(negedge clk); w7(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (if7.rd_valid !== 1'b1 || if7.rd_data !== 8'h90) begin
            errors++; $display("FAIL rm_pre got v%0h d%0h exp v1 d90", if7.rd_valid, if7.rd_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (if7.rd_valid !== 1'b0 || if7.rd_data !== 8'h00 || if7.rd_first !== 1'b0 || if7.rd_last !== 1'b0) begin
            errors++; $display("FAIL rm_outputs got v%0h d%0h f%0h l%0h exp 0 0 0 0", if7.rd_valid, if7.rd_data, if7.rd_first, if7.rd_last);
        end
        checks++; if (if7.empty !== 1'b1 || if7.full !== 1'b0 || if7.level !== 8'd0 || if7.pkt_count !== 8'd0 || if7.drop_count !== 16'd0) begin
            errors++; $display("FAIL rm_status got empty%0h full%0h level%0d pkt%0d drop%0d exp 1 0 0 0 0",
                               if7.empty, if7.full, if7.level, if7.pkt_count, if7.drop_count);
        end
        @(negedge clk); rst = 1'b0;
        if7.rd_ready = 1'b1;
        got.delete(); collect7(6);
        checks++; if (got.size() != 0) begin errors++; $display("FAIL rm_staged_leak got %0d beats exp 0", got.size()); end
        w7(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
        @(negedge clk); w7(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        got.delete(); collect7(6);
        checks++; if (got.size() != 1 || got[0] !== {2'b11, 8'hEE}) begin
            errors++; $display("FAIL rm_after got %0d beats first %0h exp 1 beats 3ee", got.size(), (got.size() > 0) ? got[0] : 10'h000);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        w7(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        w3(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        if7.rd_ready = 1'b0;
        if3.rd_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single_packet();
        test_abort();
        test_frame_err();
        test_backpressure();
        test_stream();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
